// File: rtl/text_renderer_if.sv
// Bundle of pixel-stream, text-buffer write and glyph-ROM signals for text_renderer.
// The renderer is the slave; the video timing / ROM side is the master.
interface text_renderer_if;
    logic [9:0] x;
    logic [8:0] y;
    logic       blank_in;
    logic       frame_start;
    logic       blink_en;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] char_code;
    logic [2:0] row;
    logic [7:0] pixels;
    logic       text_on;
    logic       blank_out;

    modport master (
        output x, y, blank_in, frame_start, blink_en, wr_en, wr_addr, wr_data, pixels,
        input  char_code, row, text_on, blank_out
    );

    modport slave (
        input  x, y, blank_in, frame_start, blink_en, wr_en, wr_addr, wr_data, pixels,
        output char_code, row, text_on, blank_out
    );
endinterface

// File: rtl/text_renderer.sv
// Single-line text overlay: maps pixel coordinates to glyph ROM addresses and
// produces a lit-pixel flag three clocks later, with optional frame-based blinking.
module text_renderer #(
    parameter logic [9:0] ORIGIN_X     = 10'd64,
    parameter logic [8:0] ORIGIN_Y     = 9'd32,
    parameter int         NCHARS       = 16,
    parameter int         SCALE_LOG2   = 0,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic          clk,
    input  logic          reset,
    text_renderer_if.slave bus
);
    localparam int BOX_W = 8 * NCHARS * (1 << SCALE_LOG2);
    localparam int BOX_H = 8 << SCALE_LOG2;

    logic [7:0]       text_buf_q [16];
    logic [7:0]       text_buf_d [16];

    logic [7:0]       char_code_q, char_code_d;
    logic [2:0]       row_q, row_d;
    logic [2:0][2:0]  col_sr_q, col_sr_d;
    logic [2:0]       inbox_sr_q, inbox_sr_d;
    logic [2:0]       blank_sr_q, blank_sr_d;
    logic             text_on_q, text_on_d;
    logic             blank_out_q, blank_out_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             visible_q, visible_d;

    logic [9:0]       dx;
    logic [8:0]       dy;
    logic             inbox_c;
    logic [3:0]       char_idx;
    logic [2:0]       col_c;
    logic             pixel_bit;

    // Coordinate decode; the explicit >= guards keep wrapped differences from hitting the box.
    always_comb begin
        dx       = bus.x - ORIGIN_X;
        dy       = bus.y - ORIGIN_Y;
        inbox_c  = (bus.x >= ORIGIN_X) && ({1'b0, dx} < 11'(BOX_W)) &&
                   (bus.y >= ORIGIN_Y) && ({1'b0, dy} < 10'(BOX_H));
        char_idx = 4'(dx >> (3 + SCALE_LOG2));
        col_c    = inbox_c ? 3'(dx >> SCALE_LOG2) : 3'd0;
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            text_buf_d[i] = text_buf_q[i];
        end
        if (bus.wr_en && (int'(bus.wr_addr) < NCHARS)) begin
            text_buf_d[bus.wr_addr] = bus.wr_data;
        end
    end

    // S1 reads text_buf_q, so a same-edge write is seen one clock later.
    always_comb begin
        char_code_d = inbox_c ? text_buf_q[char_idx] : 8'h20;
        row_d       = inbox_c ? 3'(dy >> SCALE_LOG2) : 3'd0;
        col_sr_d    = {col_sr_q[1:0], col_c};
        inbox_sr_d  = {inbox_sr_q[1:0], inbox_c};
        blank_sr_d  = {blank_sr_q[1:0], bus.blank_in};
        pixel_bit   = bus.pixels[3'd7 - col_sr_q[2]];
        text_on_d   = pixel_bit & inbox_sr_q[2] & ~blank_sr_q[2] & visible_q;
        blank_out_d = blank_sr_q[2];
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        visible_d   = visible_q;
        if (!bus.blink_en) begin
            frame_cnt_d = 8'd0;
            visible_d   = 1'b1;
        end else if (bus.frame_start) begin
            if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = 8'd0;
                visible_d   = ~visible_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                text_buf_q[i] <= 8'h20;
            end
            char_code_q <= 8'h20;
            row_q       <= 3'd0;
            col_sr_q    <= '0;
            inbox_sr_q  <= 3'b000;
            blank_sr_q  <= 3'b111;
            text_on_q   <= 1'b0;
            blank_out_q <= 1'b1;
            frame_cnt_q <= 8'd0;
            visible_q   <= 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                text_buf_q[i] <= text_buf_d[i];
            end
            char_code_q <= char_code_d;
            row_q       <= row_d;
            col_sr_q    <= col_sr_d;
            inbox_sr_q  <= inbox_sr_d;
            blank_sr_q  <= blank_sr_d;
            text_on_q   <= text_on_d;
            blank_out_q <= blank_out_d;
            frame_cnt_q <= frame_cnt_d;
            visible_q   <= visible_d;
        end
    end

    assign bus.char_code = char_code_q;
    assign bus.row       = row_q;
    assign bus.text_on   = text_on_q;
    assign bus.blank_out = blank_out_q;
endmodule

// File: doc/text_renderer.md
TEXT_RENDERER -- requirements
Module: text_renderer

Interface
REQ-001 SHALL have parameter ORIGIN_X, default 10'd64: left pixel column of the text box.
REQ-002 SHALL have parameter ORIGIN_Y, default 9'd32: top pixel row of the text box.
REQ-003 SHALL have parameter NCHARS, default 16: characters per line, legal range 1-16.
REQ-004 SHALL have parameter SCALE_LOG2, default 0: glyph magnification of 2^SCALE_LOG2, legal range 0-2.
REQ-005 SHALL have parameter BLINK_FRAMES, default 30: frames per blink half-period, legal range 1-255.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have ports x and y, input, 10 and 9 bits: current display pixel coordinate, sampled every clk.
REQ-009 SHALL have port blank_in, input, 1 bit: display blanking for the current coordinate.
REQ-010 SHALL have port frame_start, input, 1 bit: one-cycle pulse at the start of each frame.
REQ-011 SHALL have port blink_en, input, 1 bit: enables blinking.
REQ-012 SHALL have ports wr_en, wr_addr and wr_data, input, 1, 4 and 8 bits: text buffer write port.
REQ-013 SHALL have ports char_code and row, output, 8 and 3 bits: glyph ROM address request.
REQ-014 SHALL have port pixels, input, 8 bits: glyph ROM data, valid one clk after the address is sampled.
REQ-015 SHALL have ports text_on and blank_out, output, 1 bit each: lit text pixel and delayed blank.

Function
REQ-016 SHALL hold an internal 16x8 text buffer; on wr_en, wr_data is written to entry wr_addr at the clk edge.
REQ-017 SHALL ignore writes with wr_addr >= NCHARS.
REQ-018 SHALL use a 3-stage pipeline: S1 registers char_code/row, S2 is the ROM read, S3 registers text_on/blank_out; x/y/blank_in sampled at edge N appear at text_on/blank_out after edge N+3.
REQ-019 SHALL define dx = x - ORIGIN_X and dy = y - ORIGIN_Y; the coordinate is in-box iff x >= ORIGIN_X, dx < 8*NCHARS*2^SCALE_LOG2, y >= ORIGIN_Y and dy < 8*2^SCALE_LOG2.
REQ-020 SHALL, for an in-box coordinate, drive char_code = buffer[dx >> (3+SCALE_LOG2)], row = (dy >> SCALE_LOG2)[2:0] and col = (dx >> SCALE_LOG2)[2:0].
REQ-021 SHALL, for an out-of-box coordinate, drive char_code = 8'h20 and row = 0, and force that coordinate's in-box flag to 0.
REQ-022 SHALL carry col, the in-box flag and blank_in alongside the ROM latency, using shift registers of matching depth.
REQ-023 SHALL make pixels[7] the leftmost glyph column; in S3, text_on = pixels[7-col] & inbox & ~blank & visible.
REQ-024 SHALL compute blank_out as blank_in delayed exactly 3 clks.
REQ-025 SHALL have S1 read the buffer value present before the same-edge write; a write becomes visible to S1 on the next clk.
REQ-026 SHALL keep an 8-bit frame counter that increments on frame_start; at BLINK_FRAMES-1 plus a frame_start it wraps to 0 and toggles the visible flag.
REQ-027 SHALL force visible to 1 while blink_en = 0, with the counter held at 0; visible SHALL change only on a frame_start edge.
REQ-028 SHALL pipeline with no stalls or handshake: one coordinate is accepted every clk.
REQ-029 SHALL wrap x/y comparisons in 10/9-bit arithmetic, with no false in-box hit when x < ORIGIN_X.

Reset
REQ-030 SHALL, on reset at any edge, set text_on = 0, blank_out = 1, char_code = 8'h20, row = 0, all pipeline stages to the blanked and out-of-box state, the frame counter to 0 and visible to 1.
REQ-031 SHALL fill all buffer entries with 8'h20 on reset; reset dominates a simultaneous wr_en.
REQ-032 SHALL, after reset deasserts, produce valid text_on for a coordinate applied at edge N on edge N+3.

Verification
REQ-033 SHALL cover: reset, write 8'h41 to entry 0, with the ROM model's 'A' row 0 = 8'h18; sweep x = 64..71 at y = 32 -> text_on = 0,0,0,1,1,0,0,0 starting 3 clks after x = 64.
REQ-034 SHALL cover: x = 63 and x = 64+128 with y = 32 -> char_code = 8'h20 and text_on = 0.
REQ-035 SHALL cover: SCALE_LOG2 = 1 with x = 64..79 -> each glyph column lit for 2 consecutive pixels, and row = 0 for y = 32..33, 1 for y = 34.
REQ-036 SHALL cover: blink_en = 1, BLINK_FRAMES = 2, a lit pixel each frame -> text_on 1,1,0,0,1 across frames 0-4.
REQ-037 SHALL cover: a wr_en to entry 0 on the same edge S1 reads entry 0 -> old code used, new code used on the next clk.
REQ-038 SHALL cover: reset asserted mid-sweep -> text_on = 0 and blank_out = 1 the next clk, and the buffer reads back 8'h20.
